// File: rtl/change_dispenser.sv
// change_dispenser: computes change for a sale and pays it out coin by coin through a req/ack hopper
module change_dispenser #(
    parameter int AMT_W       = 8,
    parameter int D0          = 20,
    parameter int D1          = 10,
    parameter int D2          = 5,
    parameter int INV_W       = 6,
    parameter int INV_INIT    = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AMT_W-1:0] current_amount,
    input  logic [AMT_W-1:0] product_price,
    input  logic             coin_ack,
    input  logic [2:0]       refill,
    output logic             busy,
    output logic [2:0]       coin_req,
    output logic [AMT_W-1:0] change_amount,
    output logic             valid_transaction,
    output logic [AMT_W-1:0] shortfall,
    output logic             fault,
    output logic             done,
    output logic [INV_W-1:0] inv0,
    output logic [INV_W-1:0] inv1,
    output logic [INV_W-1:0] inv2
);
    localparam logic [2:0] IDLE = 3'd0, CALC = 3'd1, SELECT = 3'd2, WAIT_ACK = 3'd3, DONE = 3'd4;
    localparam int TW = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [AMT_W-1:0] V0 = AMT_W'(D0), V1 = AMT_W'(D1), V2 = AMT_W'(D2);
    localparam logic [INV_W-1:0] INV_RST = INV_W'(INV_INIT), INV_MAX = '1;

    logic [2:0]       state;
    logic [AMT_W-1:0] amt, price, remaining, change, coin_val;
    logic [TW-1:0]    tcnt;
    logic [INV_W-1:0] inv [3];
    logic [2:0]       fit, pick, dec;
    logic             valid;

    // operand arithmetic, greedy coin choice and the inventory decrement strobe
    always_comb begin
        valid    = (price != '0) && (amt >= price);
        change   = valid ? amt - price : amt;
        fit      = {V2 <= remaining && inv[2] != '0, V1 <= remaining && inv[1] != '0, V0 <= remaining && inv[0] != '0};
        pick     = fit[0] ? 3'b001 : fit[1] ? 3'b010 : fit[2] ? 3'b100 : 3'b000;
        coin_val = coin_req[0] ? V0 : coin_req[1] ? V1 : V2;
        dec      = (state == WAIT_ACK && coin_ack) ? coin_req : 3'b000;
    end

    // transaction sequencer: latch, compute, then one coin per handshake until paid, stuck or timed out
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            amt               <= '0;
            price             <= '0;
            remaining         <= '0;
            tcnt              <= '0;
            busy              <= 1'b0;
            coin_req          <= 3'b000;
            change_amount     <= '0;
            valid_transaction <= 1'b0;
            shortfall         <= '0;
            fault             <= 1'b0;
            done              <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    amt               <= current_amount;
                    price             <= product_price;
                    fault             <= 1'b0;
                    shortfall         <= '0;
                    change_amount     <= '0;
                    valid_transaction <= 1'b0;
                    busy              <= 1'b1;
                    state             <= CALC;
                end
                CALC: begin
                    change_amount     <= change;
                    valid_transaction <= valid;
                    remaining         <= change;
                    state             <= SELECT;
                end
                SELECT: if (pick != 3'b000) begin
                    coin_req <= pick;
                    tcnt     <= '0;
                    state    <= WAIT_ACK;
                end else begin
                    shortfall <= remaining;
                    done      <= 1'b1;
                    state     <= DONE;
                end
                WAIT_ACK: if (coin_ack) begin
                    coin_req  <= 3'b000;
                    remaining <= remaining - coin_val;
                    state     <= SELECT;
                end else if (tcnt == T_LAST) begin
                    coin_req  <= 3'b000;
                    fault     <= 1'b1;
                    shortfall <= remaining;
                    done      <= 1'b1;
                    state     <= DONE;
                end else begin
                    tcnt <= tcnt + TW'(1);
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // coin inventories: saturating refill, decrement on ack, simultaneous refill and ack cancel out
    always_ff @(posedge clk)
        for (int i = 0; i < 3; i++)
            inv[i] <= reset ? INV_RST
                    : (refill[i] && !dec[i] && inv[i] != INV_MAX) ? inv[i] + INV_W'(1)
                    : (dec[i] && !refill[i]) ? inv[i] - INV_W'(1)
                    : inv[i];

    assign inv0 = inv[0];
    assign inv1 = inv[1];
    assign inv2 = inv[2];
endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Parametrised successor to the single-shot change calculator. Latches inserted amount and product price on a start pulse and computes the change and validity. It then pays the change out as coins, one per req/ack handshake with the coin hopper. Coins are chosen greedily from three denominations, each with its own inventory counter, and the block reports any shortfall, hopper timeout and completion.

Parameters:
AMT_W, 8, width of amount/price/change/shortfall
D0, 20, largest coin value (D0 > D1 > D2 > 0, all < 2^AMT_W)
D1, 10, middle coin value
D2, 5, smallest coin value
INV_W, 6, width of each inventory counter
INV_INIT, 8, inventory count per denomination after reset
ACK_TIMEOUT, 16, max cycles waiting for coin_ack before abort

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request a transaction; sampled only in IDLE
current_amount  in  AMT_W  money inserted
product_price  in  AMT_W  price; 0 = cancel
coin_ack  in  1  hopper has ejected the requested coin
refill  in  3  one-hot-per-bit pulse: add one coin to inventory[i]
busy  out  1  high from the cycle after start accepted until after done
coin_req  out  3  one-hot coin request, bit0 = D0; held until ack or timeout
change_amount  out  AMT_W  computed change, held until next start
valid_transaction  out  1  price>0 && amount>=price, held until next start
shortfall  out  AMT_W  change not paid, valid when done
fault  out  1  hopper timeout occurred in this transaction, held until next start
done  out  1  one-cycle completion pulse
inv0, inv1, inv2  out  INV_W  current inventory counts

Behaviour:
- Reset: every output is 0 except inv0..inv2, which load INV_INIT. State is IDLE, the timeout counter is 0, and the latched operands are 0.
- Reset mid-transaction: aborts immediately. No done pulse is produced, and no inventory is decremented for an un-acked coin.
- FSM states: IDLE, CALC, SELECT, WAIT_ACK, DONE.
- IDLE:
  - start=1 latches amount and price and moves to CALC.
  - In the same edge, fault, shortfall, change_amount and valid_transaction clear to 0.
  - busy is high from the next cycle.
- CALC (1 cycle):
  - valid = (price != 0) && (amount >= price).
  - change = valid ? amount - price : amount. No wrap is possible.
  - Registers change_amount and valid_transaction; remaining <= change.
  - Moves to SELECT.
- SELECT (1 cycle):
  - Picks the lowest index i with D_i <= remaining and inv_i > 0.
  - If a coin is found: coin_req[i] <= 1, timeout counter <= 0, go to WAIT_ACK.
  - If remaining == 0 or no coin fits: go to DONE.
- WAIT_ACK:
  - coin_ack=1: coin_req <= 0, remaining -= D_i, inv_i -= 1, go to SELECT.
  - No ack: the counter increments. When it reaches ACK_TIMEOUT-1 without ack: coin_req <= 0, fault <= 1, go to DONE. Remaining is unchanged.
  - coin_ack while not in WAIT_ACK is ignored.
- DONE (1 cycle): done=1, shortfall <= remaining, busy=0 from next cycle, go to IDLE.
- Back-to-back: start is accepted in the cycle after done.
- Latency: zero-change transaction, start edge to done high = 3 cycles. Each coin adds 1 + ack-wait cycles.
- start while busy is ignored; inputs are not re-sampled mid-transaction.
- refill[i]: inv_i += 1, saturating at 2^INV_W-1, in any state.
  - Same-cycle refill and ack decrement of the same inventory: net unchanged.
  - A refill lands before the next SELECT, so it can satisfy the current transaction.

Test Plan:
- Exact change: amount=50, price=15 -> change=35, valid=1. coin_req sequence D0, D1, D2 (ack 1 cycle later each); shortfall=0; inv = 7, 7, 7.
- Insufficient funds and cancel: amount=10, price=15 -> valid=0, change=10, one D1 coin. Then amount=10, price=0 -> valid=0, change=10.
- Depleted denomination: inv1 driven to 0 by prior transactions, amount=35, price=0 -> coins D0, D2, D2, D2; shortfall=0; inv2 decremented by 3.
- Shortfall: all inventories drained except inv2=1, change=15 -> one D2, then done with shortfall=10.
- Hopper timeout: change=20, coin_ack never asserted -> coin_req[0] held ACK_TIMEOUT cycles, then fault=1, shortfall=20, inv0 unchanged. Also check start asserted while busy is ignored.
- Reset mid-WAIT_ACK with coin_req high -> next cycle all outputs 0, inv reload INV_INIT, no done pulse. Include same-cycle refill[1] + ack of a D1 coin -> inv1 unchanged.
